// File: rtl/bist_pkg.sv
// bist_pkg: shared types and constants for the s298 BIST controller and its MISR.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package bist_pkg;

    // Width of both the pattern-generator LFSR and the signature register.
    localparam int BIST_W = 16;

    // Tap mask for x^16+x^14+x^13+x^11+1 on a shift-left Fibonacci LFSR:
    // bits 15,13,12,10 feed the XOR that becomes the new bit 0.
    localparam logic [BIST_W-1:0] TPG_POLY  = 16'hB400;

    // Feedback polynomial folded in when the MISR's top bit shifts out.
    localparam logic [BIST_W-1:0] MISR_POLY = 16'h100B;

    // Controller phases, in the order a run walks through them.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } bist_state_e;

    // One step of the pattern generator: shift left, parity of the taps enters at bit 0.
    function automatic logic [BIST_W-1:0] lfsr_step(input logic [BIST_W-1:0] v);
        return {v[BIST_W-2:0], ^(v & TPG_POLY)};
    endfunction

endpackage

// File: rtl/bist_misr.sv
// bist_misr: multiple-input signature register, W bits wide, IN_W-bit parallel input.
// Latency: one cycle from din_i to sig_o when en_i is high.
// Backpressure: none; clr_i beats en_i, rst_i beats both.
module bist_misr
    import bist_pkg::*;
#(
    parameter int              W    = BIST_W,
    parameter logic [W-1:0]    POLY = MISR_POLY,
    parameter int              IN_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic [IN_W-1:0] din_i,
    output logic [W-1:0]    sig_o
);

    logic [W-1:0] sig_q;
    logic [W-1:0] sig_d;

    // Next signature: shift left, fold POLY in when the top bit falls off, XOR the new response.
    always_comb begin
        sig_d = {sig_q[W-2:0], 1'b0}
              ^ (sig_q[W-1] ? POLY : '0)
              ^ {{(W-IN_W){1'b0}}, din_i};
    end

    // Signature register: reset and clear both return to zero; otherwise compact when enabled.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            sig_q <= '0;
        end else if (en_i) begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/s298_bist_ctrl.sv
// s298_bist_ctrl: BIST sequencer for s298 - INIT (G0 held high), pseudo-random RUN, DRAIN, DONE with MISR compare.
// Latency: done rises INIT_CYCLES + PATTERN_COUNT + 2 cycles after start is sampled; busy covers the cycles before that.
// Backpressure: none; start honoured only in IDLE/DONE. Optional abort port built when BIST_ABORT_EN is defined.
module s298_bist_ctrl
    import bist_pkg::*;
#(
    parameter int unsigned       PATTERN_COUNT = 256,
    parameter int unsigned       INIT_CYCLES   = 4,
    parameter logic [BIST_W-1:0] TPG_SEED      = 16'hACE1,
    parameter logic [BIST_W-1:0] GOLDEN_SIG    = 16'h0000
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              start,
`ifdef BIST_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [BIST_W-1:0] signature,
    output logic              cut_g0,
    output logic              cut_g1,
    output logic              cut_g2,
    input  logic [5:0]        cut_out
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [BIST_W-1:0] SEED_EFF  = (TPG_SEED == '0) ? 16'h0001 : TPG_SEED;
    // Terminal counts: counters run 0..N-1 inside each timed phase.
    localparam logic [BIST_W-1:0] INIT_LAST = BIST_W'(INIT_CYCLES - 1);
    localparam logic [BIST_W-1:0] RUN_LAST  = BIST_W'(PATTERN_COUNT - 1);

    bist_state_e       state_q;
    logic [BIST_W-1:0] cnt_q;
    logic [BIST_W-1:0] lfsr_q;
    logic [BIST_W-1:0] lfsr_nxt;
    logic              busy_q;
    logic              done_q;
    logic              aborted_q;
    logic [2:0]        cut_q;

    logic              start_ok;
    logic              abort_req;
    logic              misr_clr;
    logic              misr_en;
    logic [BIST_W-1:0] misr_sig;

`ifdef BIST_ABORT_EN
    // Abort only matters while a run is in flight.
    assign abort_req = abort & busy_q;
`else
    assign abort_req = 1'b0;
`endif

    assign lfsr_nxt = lfsr_step(lfsr_q);
    assign start_ok = start & ((state_q == IDLE) | (state_q == DONE));

    // Signature is zeroed on the edge that enters INIT and stays zero throughout INIT.
    assign misr_clr = start_ok | (state_q == INIT);

    // s298 registers its outputs, so the response to pattern i arrives during RUN cycle i+1
    // (or DRAIN for the last one). Skipping RUN cycle 0 gives exactly PATTERN_COUNT updates.
    assign misr_en  = ((state_q == RUN) & (cnt_q != '0)) | (state_q == DRAIN);

    bist_misr #(
        .W    (BIST_W),
        .POLY (MISR_POLY),
        .IN_W (6)
    ) u_misr (
        .clk_i (CK),
        .rst_i (RST),
        .clr_i (misr_clr),
        .en_i  (misr_en & ~abort_req),
        .din_i (cut_out),
        .sig_o (misr_sig)
    );

    // Sequencer: phase, phase counter, pattern LFSR and the registered status/pattern outputs.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lfsr_q    <= SEED_EFF;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            cut_q     <= 3'b000;
        end else if (abort_req) begin
            // Stop where we are; the MISR enable is gated off on this same edge.
            state_q   <= DONE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
            cut_q     <= 3'b000;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q   <= INIT;
                        cnt_q     <= '0;
                        lfsr_q    <= SEED_EFF;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        aborted_q <= 1'b0;
                        cut_q     <= 3'b001;
                    end
                end
                INIT: begin
                    lfsr_q <= SEED_EFF;
                    if (cnt_q == INIT_LAST) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        cut_q   <= SEED_EFF[2:0];
                    end else begin
                        cnt_q   <= cnt_q + 16'd1;
                        cut_q   <= 3'b001;
                    end
                end
                RUN: begin
                    lfsr_q <= lfsr_nxt;
                    if (cnt_q == RUN_LAST) begin
                        state_q <= DRAIN;
                        cnt_q   <= '0;
                        cut_q   <= 3'b000;
                    end else begin
                        cnt_q   <= cnt_q + 16'd1;
                        cut_q   <= lfsr_nxt[2:0];
                    end
                end
                DRAIN: begin
                    state_q <= DONE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    cut_q   <= 3'b000;
                end
                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    aborted_q <= 1'b0;
                    cut_q     <= 3'b000;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign signature = misr_sig;
    assign pass      = done_q & ~aborted_q & (misr_sig == GOLDEN_SIG);
    assign cut_g0    = cut_q[0];
    assign cut_g1    = cut_q[1];
    assign cut_g2    = cut_q[2];

endmodule

// File: tb/tb_s298_bist_ctrl.sv
// tb_s298_bist_ctrl: stubbed-CUT checks on short runs plus randomized runs against a timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_s298_bist_ctrl;

    localparam int IC   = 4;
    localparam int PC_S = 2;
    localparam int PC_R = 40;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int K_DONE = IC + PC_R + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst       = 1'b1;
    logic       start_s   = 1'b0;
    logic       start_r   = 1'b0;
    logic [5:0] cut_out_s = 6'h00;
    logic [5:0] cut_out_r = 6'h00;
`ifdef BIST_ABORT_EN
    logic       abort_s   = 1'b0;
    logic       abort_r   = 1'b0;
`endif

    logic        busy_s, done_s, pass_s;
    logic [15:0] sig_s;
    logic [2:0]  g_s;
    logic        busy_1, done_1, pass_1;
    logic [15:0] sig_1;
    logic [2:0]  g_1;
    logic        busy_r, done_r, pass_r;
    logic [15:0] sig_r;
    logic [2:0]  g_r;

    s298_bist_ctrl #(.PATTERN_COUNT(PC_S), .INIT_CYCLES(IC)) dut_s (
        .CK(clk), .RST(rst), .start(start_s),
`ifdef BIST_ABORT_EN
        .abort(abort_s),
`endif
        .busy(busy_s), .done(done_s), .pass(pass_s), .signature(sig_s),
        .cut_g0(g_s[0]), .cut_g1(g_s[1]), .cut_g2(g_s[2]), .cut_out(cut_out_s)
    );

    s298_bist_ctrl #(.PATTERN_COUNT(1), .INIT_CYCLES(IC)) dut_1 (
        .CK(clk), .RST(rst), .start(start_s),
`ifdef BIST_ABORT_EN
        .abort(1'b0),
`endif
        .busy(busy_1), .done(done_1), .pass(pass_1), .signature(sig_1),
        .cut_g0(g_1[0]), .cut_g1(g_1[1]), .cut_g2(g_1[2]), .cut_out(cut_out_s)
    );

    s298_bist_ctrl #(.PATTERN_COUNT(PC_R), .INIT_CYCLES(IC)) dut_r (
        .CK(clk), .RST(rst), .start(start_r),
`ifdef BIST_ABORT_EN
        .abort(abort_r),
`endif
        .busy(busy_r), .done(done_r), .pass(pass_r), .signature(sig_r),
        .cut_g0(g_r[0]), .cut_g1(g_r[1]), .cut_g2(g_r[2]), .cut_out(cut_out_r)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Signature rule straight from the definition.
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [5:0] d);
        logic [15:0] r;
        r = s << 1;
        if (s[15]) r = r ^ 16'h100B;
        return r ^ {10'd0, d};
    endfunction

    // Pattern sequence seen on {g2,g1,g0}, one entry per RUN cycle.
    logic [2:0] pat [0:PC_R-1];
    // Per-cycle response stub for dut_r, indexed by cycles since start.
    logic [5:0] rv [0:63];

    // Expected signature of a clean run: responses land at cycles IC+2 .. IC+PC_R+1 after start.
    function automatic logic [15:0] calc_sig();
        logic [15:0] s;
        s = 16'h0000;
        for (int c = IC + 2; c <= IC + PC_R + 1; c++) s = misr_step(s, rv[c]);
        return s;
    endfunction

    // ---- timeline model of dut_r: mk = cycles since the accepted start (-1 idle, K_DONE = done)
    int          mk   = -1;
    logic [15:0] msig = 16'h0000;
    bit          mab  = 1'b0;
    bit          cmp_on = 1'b0;
    logic        ab_r_v;
`ifdef BIST_ABORT_EN
    assign ab_r_v = abort_r;
`else
    assign ab_r_v = 1'b0;
`endif

    always @(posedge clk) begin
        if (rst) begin
            mk = -1; msig = 16'h0000; mab = 1'b0;
        end else if (mk >= 1 && mk < K_DONE) begin
            if (ab_r_v) begin
                mk = K_DONE; mab = 1'b1;
            end else begin
                if (mk >= IC + 2) msig = misr_step(msig, cut_out_r);
                mk++;
            end
        end else if (start_r) begin
            mk = 1; msig = 16'h0000; mab = 1'b0;
        end
    end

    // Every-cycle comparison of dut_r against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            logic       e_busy, e_done, e_pass;
            logic [2:0] e_cut;
            e_busy = (mk >= 1 && mk < K_DONE);
            e_done = (mk == K_DONE);
            e_pass = e_done && !mab && (msig == 16'h0000);
            if (mk >= 1 && mk <= IC)             e_cut = 3'b001;
            else if (mk > IC && mk <= IC + PC_R) e_cut = pat[mk - IC - 1];
            else                                 e_cut = 3'b000;
            chk("m_busy", busy_r, e_busy);
            chk("m_done", done_r, e_done);
            chk("m_pass", pass_r, e_pass);
            chk("m_cut",  g_r,    e_cut);
            chk("m_sig",  sig_r,  msig);
        end
    end

    task automatic run_r(input int rst_at, input bit allow_ab, output logic [15:0] sig_end);
        start_r = 1'b1;
        for (int c = 1; c <= IC + PC_R + 4; c++) begin
            @(negedge clk);
            cut_out_r = rv[c];
            rst       = (c == rst_at);
            start_r   = (c <= IC + PC_R) && (rst_at == 0 || c < rst_at) && ($urandom_range(0, 7) == 0);
`ifdef BIST_ABORT_EN
            abort_r   = allow_ab && ($urandom_range(0, 31) == 0);
`endif
            if (c == IC + 1 && !allow_ab) chk("r_first_pat", g_r, 3'b001);
            if (rst_at != 0 && c == rst_at + 1) begin
                chk("r_rst_busy", busy_r, 1'b0);
                chk("r_rst_done", done_r, 1'b0);
                chk("r_rst_sig",  sig_r,  16'h0000);
                chk("r_rst_cut",  g_r,    3'b000);
            end
        end
        rst     = 1'b0;
        start_r = 1'b0;
`ifdef BIST_ABORT_EN
        abort_r = 1'b0;
`endif
        sig_end = sig_r;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v, s_end, exp_sig;
        int busy_cnt, busy_first, done_first, g0_init;

        v = SEED;
        for (int i = 0; i < PC_R; i++) begin
            pat[i] = v[2:0];
            v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
        end
        for (int i = 0; i < 64; i++) rv[i] = 6'($urandom);

        // ---- reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmp_on = 1'b1;
        chk("rst_busy_s", busy_s, 1'b0);
        chk("rst_done_s", done_s, 1'b0);
        chk("rst_pass_s", pass_s, 1'b0);
        chk("rst_sig_s",  sig_s,  16'h0000);
        chk("rst_cut_s",  g_s,    3'b000);
        chk("rst_busy_r", busy_r, 1'b0);
        chk("rst_sig_r",  sig_r,  16'h0000);

        // ---- zero stub: timing, INIT drive, first patterns, pass
        cut_out_s = 6'h00;
        start_s = 1'b1;
        busy_cnt = 0; busy_first = 0; done_first = 0; g0_init = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start_s = 1'b0;
            if (busy_s) begin busy_cnt++; if (busy_first == 0) busy_first = c; end
            if (done_s && done_first == 0) done_first = c;
            if (c <= IC && g_s == 3'b001) g0_init++;
            if (c == 5) chk("s_run0_cut", g_s, 3'b001);
            if (c == 6) chk("s_run1_cut", g_s, 3'b011);
            if (c == 7) chk("s_drain_cut", g_s, 3'b000);
            if (c == 7) begin
                chk("one_done", done_1, 1'b1);
                chk("one_sig0", sig_1, 16'h0000);
                chk("one_pass0", pass_1, 1'b1);
                chk("one_busy", busy_1, 1'b0);
                chk("one_cut", g_1, 3'b000);
            end
            if (c == 8) begin
                chk("s_sig0", sig_s, 16'h0000);
                chk("s_pass0", pass_s, 1'b1);
            end
        end
        chk("s_busy_first", busy_first, 1);
        chk("s_busy_cnt", busy_cnt, 7);
        chk("s_done_first", done_first, 8);
        chk("s_g0_init", g0_init, 4);

        // ---- stub 1, restarted from DONE
        cut_out_s = 6'h01;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        chk("s_restart_done", done_s, 1'b0);
        chk("s_restart_busy", busy_s, 1'b1);
        chk("s_restart_cut", g_s, 3'b001);
        repeat (9) @(negedge clk);
        chk("s_sig1", sig_s, 16'h0003);
        chk("s_pass1", pass_s, 1'b0);
        chk("one_sig1", sig_1, 16'h0001);
        chk("one_pass1", pass_1, 1'b0);

        // ---- start during RUN is ignored
        cut_out_s = 6'h00;
        start_s = 1'b1;
        busy_cnt = 0; done_first = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start_s = (c == 5);
            if (busy_s) busy_cnt++;
            if (done_s && done_first == 0) done_first = c;
        end
        chk("s_ign_done", done_first, 8);
        chk("s_ign_busy", busy_cnt, 7);

`ifdef BIST_ABORT_EN
        // ---- abort in RUN: done next cycle, pass forced low, signature frozen
        cut_out_s = 6'h01;
        start_s = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start_s = 1'b0;
            abort_s = (c == 6);
            if (c == 7) begin
                chk("ab_done", done_s, 1'b1);
                chk("ab_busy", busy_s, 1'b0);
                chk("ab_pass", pass_s, 1'b0);
                chk("ab_sig", sig_s, 16'h0000);
            end
            if (c == 9) chk("ab_sig_hold", sig_s, 16'h0000);
        end
        abort_s = 1'b0;
`endif

        // ---- randomized runs on dut_r: clean, reset mid-run, then two more clean reruns
        exp_sig = calc_sig();
        run_r(0, 1'b0, s_end);
        chk("r_sig_run1", s_end, exp_sig);
        run_r(IC + 3, 1'b0, s_end);
        repeat (2) @(negedge clk);
        run_r(0, 1'b0, s_end);
        chk("r_sig_run2", s_end, exp_sig);
        run_r(0, 1'b0, s_end);
        chk("r_sig_run3", s_end, exp_sig);

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 64; i++) rv[i] = 6'($urandom);
            exp_sig = calc_sig();
            run_r(0, 1'b0, s_end);
            chk("r_sig_rand", s_end, exp_sig);
        end
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 64; i++) rv[i] = 6'($urandom);
            run_r(0, 1'b1, s_end);
        end
        repeat (IC + PC_R + 4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
